// File: rtl/mips_mc_control.sv
// mips_mc_control
//   Multi-cycle main control FSM for a 32-bit MIPS datapath. Each instruction
//   is sequenced over several cycles that share one ALU and one memory port.
//   The block drives the datapath select and strobe lines and the
//   immediate-generator mode. It stalls while memory inserts wait states.
//   It traps on an undefined opcode or on a memory wait that runs too long.
//
//   Parameters
//     STALL_TIMEOUT  longest mem_ready wait in FETCH/MEMRD/MEMWR before the
//                    bus error trap; 0 disables the timeout
//     CNT_W          width of the wait-cycle counter (must hold STALL_TIMEOUT)
//
//   Ports
//     clk, rst_n        clock (rising edge), asynchronous active-low reset
//     opcode            instr[31:26] from the instruction register
//     mem_ready         memory finishes the current access this cycle
//     pc_write          unconditional PC load
//     pc_write_cond     PC load if ALU zero
//     pc_write_ne       PC load if ALU not zero
//     iord              memory address: 0 = PC, 1 = ALUOut
//     mem_read          memory read strobe
//     mem_write         memory write strobe
//     ir_write          instruction register load
//     reg_dst           register destination: 0 = rt, 1 = rd
//     mem_to_reg        register write data: 0 = ALUOut, 1 = MDR
//     reg_write         register file write strobe
//     alu_src_a         ALU A operand: 0 = PC, 1 = regA
//     alu_src_b         ALU B operand: regB / 4 / ImmExt / ImmExt<<2
//     alu_op            ALU operation: add / sub / funct / slt
//     pc_src            next PC source: ALU / ALUOut / jump target
//     imm_sel           immediate mode: sign-ext / upper / zero-ext
//     retire            pulses in the last cycle of a completed instruction
//     illegal_op        sticky flag for an undefined opcode
//     bus_err           sticky flag for a mem_ready timeout
//     state_o           current state encoding, for debug
module mips_mc_control #(
    parameter int STALL_TIMEOUT = 255,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [1:0] imm_sel,
    output logic       retire,
    output logic       illegal_op,
    output logic       bus_err,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_REX    = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_IEX    = 4'd10,
        S_IWB    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam bit             TIMEOUT_EN   = (STALL_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST =
        CNT_W'((STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             illegal_op_reg;
    logic             bus_err_reg;
    logic             wait_state;
    logic             timeout_hit;

    assign wait_state  = (state_reg == S_FETCH) || (state_reg == S_MEMRD) ||
                         (state_reg == S_MEMWR);
    // Trap is taken in the last permitted waiting cycle. A mem_ready in that
    // same cycle wins, so an access that completes just in time is not lost.
    assign timeout_hit = TIMEOUT_EN && !mem_ready && (wait_cnt_reg == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            wait_cnt_reg   <= '0;
            illegal_op_reg <= 1'b0;
            bus_err_reg    <= 1'b0;
        end else begin
            // The counter runs only while stalled in a wait state. It reads
            // zero on every entry because all other cycles clear it.
            if (wait_state && !mem_ready)
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            else
                wait_cnt_reg <= '0;

            if (wait_state && timeout_hit) begin
                state_reg   <= S_TRAP;
                bus_err_reg <= 1'b1;
            end else begin
                case (state_reg)
                    S_IDLE:   state_reg <= S_FETCH;
                    S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            OP_LW, OP_SW:              state_reg <= S_MEMADR;
                            OP_RTYPE:                  state_reg <= S_REX;
                            OP_BEQ, OP_BNE:            state_reg <= S_BRANCH;
                            OP_ADDI, OP_SLTI, OP_LUI:  state_reg <= S_IEX;
                            OP_J:                      state_reg <= S_JUMP;
                            default: begin
                                state_reg      <= S_TRAP;
                                illegal_op_reg <= 1'b1;
                            end
                        endcase
                    end
                    S_MEMADR: state_reg <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                    S_MEMRD:  if (mem_ready) state_reg <= S_MEMWB;
                    S_MEMWB:  state_reg <= S_FETCH;
                    S_MEMWR:  if (mem_ready) state_reg <= S_FETCH;
                    S_REX:    state_reg <= S_RWB;
                    S_RWB:    state_reg <= S_FETCH;
                    S_BRANCH: state_reg <= S_FETCH;
                    S_IEX:    state_reg <= S_IWB;
                    S_IWB:    state_reg <= S_FETCH;
                    S_JUMP:   state_reg <= S_FETCH;
                    S_TRAP:   state_reg <= S_TRAP;
                    default:  state_reg <= S_IDLE;
                endcase
            end
        end
    end

    // The outputs are decoded from the registered state. Because reset clears
    // the state asynchronously, the strobes also drop as soon as rst_n falls.
    // The only input terms are mem_ready, for the handshake strobes, and
    // opcode, for the branch flavour and the immediate flavour.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_write_ne   = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        imm_sel       = 2'b00;
        retire        = 1'b0;
        case (state_reg)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_src        = 2'b01;
                pc_write_cond = (opcode == OP_BEQ);
                pc_write_ne   = (opcode == OP_BNE);
                retire        = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (opcode == OP_SLTI) ? 2'b11 : 2'b00;
                imm_sel   = (opcode == OP_LUI) ? 2'b01 : 2'b00;
            end
            S_IWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'b10;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_op = illegal_op_reg;
    assign bus_err    = bus_err_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, retire;
    logic       illegal_op, bus_err;
    logic [1:0] alu_src_b, alu_op, pc_src, imm_sel;
    logic [3:0] state_o;

    mips_mc_control #(.STALL_TIMEOUT(4), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_write_ne   (pc_write_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .imm_sel       (imm_sel),
        .retire        (retire),
        .illegal_op    (illegal_op),
        .bus_err       (bus_err),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output word, laid out MSB first:
    // pcw pwc pwne iord mrd mwr irw rdst mtr rw asa asb[2] aop[2] pcs[2] imm[2] ret ill berr st[4]
    logic [25:0] act;
    assign act = {pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write,
                  ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_op, pc_src, imm_sel, retire, illegal_op, bus_err, state_o};

    localparam logic [25:0] PCW     = 26'b1 << 25;
    localparam logic [25:0] PWC     = 26'b1 << 24;
    localparam logic [25:0] PWNE    = 26'b1 << 23;
    localparam logic [25:0] IORD    = 26'b1 << 22;
    localparam logic [25:0] MRD     = 26'b1 << 21;
    localparam logic [25:0] MWR     = 26'b1 << 20;
    localparam logic [25:0] IRW     = 26'b1 << 19;
    localparam logic [25:0] RDST    = 26'b1 << 18;
    localparam logic [25:0] MTR     = 26'b1 << 17;
    localparam logic [25:0] RW      = 26'b1 << 16;
    localparam logic [25:0] ASA     = 26'b1 << 15;
    localparam logic [25:0] ASB4    = 26'd1 << 13;
    localparam logic [25:0] ASBIMM  = 26'd2 << 13;
    localparam logic [25:0] ASBSH   = 26'd3 << 13;
    localparam logic [25:0] AOPSUB  = 26'd1 << 11;
    localparam logic [25:0] AOPFN   = 26'd2 << 11;
    localparam logic [25:0] AOPSLT  = 26'd3 << 11;
    localparam logic [25:0] PCSOUT  = 26'd1 << 9;
    localparam logic [25:0] PCSJ    = 26'd2 << 9;
    localparam logic [25:0] IMMUP   = 26'd1 << 7;
    localparam logic [25:0] RET     = 26'b1 << 6;
    localparam logic [25:0] ILL     = 26'b1 << 5;
    localparam logic [25:0] BERR    = 26'b1 << 4;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, LUI = 6'b001111;
    localparam logic [5:0] SLTI = 6'b001010, JMP = 6'b000010, BAD = 6'b111111;

    // Hand-written expected words for the cycles that occur repeatedly
    localparam logic [25:0] E_IDLE  = 26'd0;
    localparam logic [25:0] E_FW    = MRD | ASB4 | 26'd1;             // FETCH, waiting
    localparam logic [25:0] E_FR    = MRD | ASB4 | PCW | IRW | 26'd1; // FETCH, ready
    localparam logic [25:0] E_DEC   = ASBSH | 26'd2;
    localparam logic [25:0] E_MADR  = ASA | ASBIMM | 26'd3;

    typedef struct packed {
        logic [31:0] id;
        logic [25:0] v;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tag = 0;

    // Monitor: one expected word is queued per checked cycle and compared
    // here mid-cycle, once the outputs have settled after the input change.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (act !== mon_e.v) begin
                errors++;
                $display("FAIL chk%0d outputs got %h expected %h (state got %0d expected %0d)",
                         mon_e.id, act, mon_e.v, act[3:0], mon_e.v[3:0]);
            end else begin
                $display("chk%0d state=%0d outputs=%h ok", mon_e.id, act[3:0], act);
            end
        end
    end

    // Drive one cycle of inputs just after the clock edge and queue its expectation
    task automatic cyc(input logic [5:0] op, input logic mr, input logic [25:0] ev);
        opcode    = op;
        mem_ready = mr;
        tag       = tag + 1;
        exp_q.push_back({tag, ev});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = 6'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc(RT, 1'b1, E_IDLE);                     // held in reset
        rst_n = 1'b1;
        cyc(RT, 1'b1, E_IDLE);                     // first cycle after release

        // lw, memory always ready
        cyc(LW, 1'b1, E_FR);
        cyc(LW, 1'b1, E_DEC);
        cyc(LW, 1'b1, E_MADR);
        cyc(LW, 1'b1, IORD | MRD | 26'd4);
        cyc(LW, 1'b1, MTR | RW | RET | 26'd5);

        // sw with three wait states; ready lands on the last permitted cycle
        cyc(SW, 1'b1, E_FR);
        cyc(SW, 1'b1, E_DEC);
        cyc(SW, 1'b1, E_MADR);
        cyc(SW, 1'b0, IORD | MWR | 26'd6);
        cyc(SW, 1'b0, IORD | MWR | 26'd6);
        cyc(SW, 1'b0, IORD | MWR | 26'd6);
        cyc(SW, 1'b1, IORD | MWR | RET | 26'd6);

        // beq then bne
        cyc(BEQ, 1'b1, E_FR);
        cyc(BEQ, 1'b1, E_DEC);
        cyc(BEQ, 1'b0, ASA | AOPSUB | PCSOUT | PWC | RET | 26'd9);
        cyc(BNE, 1'b1, E_FR);
        cyc(BNE, 1'b1, E_DEC);
        cyc(BNE, 1'b0, ASA | AOPSUB | PCSOUT | PWNE | RET | 26'd9);

        // lui then slti
        cyc(LUI, 1'b1, E_FR);
        cyc(LUI, 1'b1, E_DEC);
        cyc(LUI, 1'b1, ASA | ASBIMM | IMMUP | 26'd10);
        cyc(LUI, 1'b1, RW | RET | 26'd11);
        cyc(SLTI, 1'b1, E_FR);
        cyc(SLTI, 1'b1, E_DEC);
        cyc(SLTI, 1'b1, ASA | ASBIMM | AOPSLT | 26'd10);
        cyc(SLTI, 1'b1, RW | RET | 26'd11);

        // R-type, then jump
        cyc(RT, 1'b1, E_FR);
        cyc(RT, 1'b1, E_DEC);
        cyc(RT, 1'b1, ASA | AOPFN | 26'd7);
        cyc(RT, 1'b1, RDST | RW | RET | 26'd8);
        cyc(JMP, 1'b1, E_FR);
        cyc(JMP, 1'b1, E_DEC);
        cyc(JMP, 1'b1, PCW | PCSJ | RET | 26'd12);

        // Undefined opcode traps and stays trapped
        cyc(BAD, 1'b1, E_FR);
        cyc(BAD, 1'b1, E_DEC);
        cyc(LW,  1'b1, ILL | 26'd13);
        cyc(RT,  1'b0, ILL | 26'd13);
        checks++;
        if (illegal_op !== 1'b1 || state_o !== 4'd13) begin
            errors++;
            $display("FAIL trap illegal_op=%b state=%0d expected 1/13", illegal_op, state_o);
        end else begin
            $display("trap illegal_op=%b state=%0d ok", illegal_op, state_o);
        end

        // Reset clears the trap, then reset again in the middle of a store
        rst_n = 1'b0;
        cyc(SW, 1'b1, E_IDLE);
        rst_n = 1'b1;
        cyc(SW, 1'b1, E_IDLE);
        cyc(SW, 1'b1, E_FR);
        cyc(SW, 1'b1, E_DEC);
        cyc(SW, 1'b1, E_MADR);
        cyc(SW, 1'b0, IORD | MWR | 26'd6);
        rst_n = 1'b0;                              // no clock edge before the check
        #1;
        checks++;
        if (mem_write !== 1'b0 || state_o !== 4'd0) begin
            errors++;
            $display("FAIL async reset mem_write=%b state=%0d expected 0/0", mem_write, state_o);
        end else begin
            $display("async reset mem_write=%b state=%0d ok", mem_write, state_o);
        end
        cyc(SW, 1'b1, E_IDLE);
        rst_n = 1'b1;
        cyc(SW, 1'b1, E_IDLE);

        // Fetch stall runs into the timeout
        cyc(RT, 1'b0, E_FW);
        cyc(RT, 1'b0, E_FW);
        cyc(RT, 1'b0, E_FW);
        cyc(RT, 1'b0, E_FW);
        cyc(RT, 1'b1, BERR | 26'd13);
        cyc(LW, 1'b1, BERR | 26'd13);
        checks++;
        if (bus_err !== 1'b1 || state_o !== 4'd13 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL timeout bus_err=%b state=%0d mem_read=%b", bus_err, state_o, mem_read);
        end else begin
            $display("timeout bus_err=%b state=%0d ok", bus_err, state_o);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %0d queued expectations never compared", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
